// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: opcodes, func/class codes, FSM states, md request payload.
// The optional ALUC_UNSIGNED_EN macro is consumed by the top level; the codes live here unconditionally.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_AND     = 4'h0;
  localparam alu_op_t ALU_OR      = 4'h1;
  localparam alu_op_t ALU_ADD     = 4'h2;
  localparam alu_op_t ALU_SUB     = 4'h3;
  localparam alu_op_t ALU_SLT     = 4'h4;
  localparam alu_op_t ALU_DIV     = 4'h5;
  localparam alu_op_t ALU_NOP     = 4'h6;
  localparam alu_op_t ALU_MUL     = 4'h7;
  localparam alu_op_t ALU_PASS_HI = 4'h8;
  localparam alu_op_t ALU_PASS_LO = 4'h9;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] UC_ADD   = 3'b000;
  localparam logic [2:0] UC_SUB   = 3'b001;
  localparam logic [2:0] UC_AND   = 3'b010;
  localparam logic [2:0] UC_OR    = 3'b011;
  localparam logic [2:0] UC_SLT   = 3'b100;
  localparam logic [2:0] UC_RTYPE = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_t;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_req_t;

endpackage

// File: rtl/md_iter.sv
// Iterative one-bit-per-cycle multiply (shift-add) / divide (restoring) datapath.
// Works on magnitudes; sign fixup and divide-by-zero result are applied on the combinational result.
module md_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_req_t          req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;

  // acc is {product} for multiply and {remainder, quotient} for divide
  logic [W2-1:0]    acc, acc_nxt, prod;
  logic [WIDTH-1:0] dvsr, raw_a, mag_a, mag_b, quo, rem;
  logic [CW-1:0]    cnt;
  logic             busy, is_div, neg_q, neg_r, sa, sb;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    sa    = req.is_signed & a[WIDTH-1];
    sb    = req.is_signed & b[WIDTH-1];
    mag_a = sa ? (~a + WIDTH'(1)) : a;
    mag_b = sb ? (~b + WIDTH'(1)) : b;
  end

  // One iteration step for each operation
  always_comb begin
    sum     = {1'b0, acc[W2-1:WIDTH]} + {1'b0, dvsr};
    shifted = acc[W2-1:WIDTH-1];
    diff    = shifted - {1'b0, dvsr};
    acc_nxt = '0;
    if (!is_div) begin
      acc_nxt = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[W2-1:1]};
    end else if (diff[WIDTH]) begin
      acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign last_c = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      dvsr   <= '0;
      raw_a  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last_c;
      if (start) begin
        acc    <= {{WIDTH{1'b0}}, mag_a};
        dvsr   <= mag_b;
        raw_a  <= a;
        cnt    <= CW'(WIDTH - 1);
        busy   <= 1'b1;
        is_div <= req.is_div;
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        dbz    <= req.is_div && (b == '0);
      end else if (busy) begin
        acc <= acc_nxt;
        cnt <= cnt - CW'(1);
        if (cnt == '0) busy <= 1'b0;
      end
    end
  end

  // Signed fixup by two's-complement negation of the magnitude result
  always_comb begin
    prod = neg_q ? (~acc + W2'(1)) : acc;
    quo  = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem  = neg_r ? (~acc[W2-1:WIDTH] + WIDTH'(1)) : acc[W2-1:WIDTH];
    if (!is_div) begin
      res_hi_c = prod[W2-1:WIDTH];
      res_lo_c = prod[WIDTH-1:0];
    end else if (dbz) begin
      res_hi_c = raw_a;
      res_lo_c = '1;
    end else begin
      res_hi_c = rem;
      res_lo_c = quo;
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control: opcode decode, mul/div sequencing FSM, pipeline stall and HI/LO.
// Define ALUC_UNSIGNED_EN to enable the MULTU/DIVU functions.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       UC_aluOp,
  input  logic [5:0]       func,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [OP_W-1:0]  ALU_aluOp,
  output logic             stall,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

`ifdef ALUC_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  md_state_t        state;
  alu_op_t          op;
  md_req_t          req;
  logic             is_md, launch_c;
  logic             md_last_c, md_done, md_dbz;
  logic [WIDTH-1:0] md_hi_c, md_lo_c;

  // Opcode decode; every unlisted encoding falls through to NOP
  always_comb begin
    op    = ALU_NOP;
    is_md = 1'b0;
    req   = '0;
    case (UC_aluOp)
      UC_ADD:   op = ALU_ADD;
      UC_SUB:   op = ALU_SUB;
      UC_AND:   op = ALU_AND;
      UC_OR:    op = ALU_OR;
      UC_SLT:   op = ALU_SLT;
      UC_RTYPE: begin
        case (func)
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_ADD:  op = ALU_ADD;
          FN_SUB:  op = ALU_SUB;
          FN_SLT:  op = ALU_SLT;
          FN_NOP:  op = ALU_NOP;
          FN_MFHI: op = ALU_PASS_HI;
          FN_MFLO: op = ALU_PASS_LO;
          FN_MULT: begin
            op            = ALU_MUL;
            is_md         = 1'b1;
            req.is_signed = 1'b1;
          end
          FN_DIV: begin
            op            = ALU_DIV;
            is_md         = 1'b1;
            req.is_div    = 1'b1;
            req.is_signed = 1'b1;
          end
          FN_MULTU: begin
            if (UNS_EN) begin
              op    = ALU_MUL;
              is_md = 1'b1;
            end
          end
          FN_DIVU: begin
            if (UNS_EN) begin
              op         = ALU_DIV;
              is_md      = 1'b1;
              req.is_div = 1'b1;
            end
          end
          default: op = ALU_NOP;
        endcase
      end
      default: op = ALU_NOP;
    endcase
  end

  assign ALU_aluOp = OP_W'(op);
  assign launch_c  = !rst && (state == ST_IDLE) && valid_in && is_md;
  assign stall     = launch_c || (!rst && ((state == ST_MUL) || (state == ST_DIV)));
  assign md_busy   = (state != ST_IDLE);

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (launch_c),
    .req      (req),
    .a        (op_a),
    .b        (op_b),
    .last_c   (md_last_c),
    .done     (md_done),
    .dbz      (md_dbz),
    .res_hi_c (md_hi_c),
    .res_lo_c (md_lo_c)
  );

  // DONE never relaunches: the stalled instruction is still decoded during it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_c) state <= req.is_div ? ST_DIV : ST_MUL;
        end
        ST_MUL, ST_DIV: begin
          if (md_last_c) begin
            state       <= ST_DONE;
            div_by_zero <= md_dbz;
          end
        end
        ST_DONE: begin
          if (md_done) begin
            hi <= md_hi_c;
            lo <= md_lo_c;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv (WIDTH=32): arithmetic reference model plus directed vectors.
// MULTU/DIVU vectors follow ALUC_UNSIGNED_EN when the bench is built with it.
module tb_alu_ctrl_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    UC_aluOp = 3'b000;
  logic [5:0]    func = 6'b000000;
  logic          valid_in = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic [3:0]    ALU_aluOp;
  logic          stall, md_busy, div_by_zero;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  alu_ctrl_muldiv #(.WIDTH(W), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .UC_aluOp(UC_aluOp), .func(func), .valid_in(valid_in),
    .op_a(op_a), .op_b(op_b), .ALU_aluOp(ALU_aluOp), .stall(stall), .md_busy(md_busy),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int rop [bit [5:0]];
  initial begin
    rop[6'b100100] = 0; rop[6'b100101] = 1; rop[6'b100000] = 2; rop[6'b100010] = 3;
    rop[6'b101010] = 4; rop[6'b000000] = 6; rop[6'b010000] = 8; rop[6'b010010] = 9;
    rop[6'b011000] = 7; rop[6'b011010] = 5;
`ifdef ALUC_UNSIGNED_EN
    rop[6'b011001] = 7; rop[6'b011011] = 5;
`endif
  end

  function automatic int exp_op(input logic [2:0] uc, input logic [5:0] fn);
    int tbl [5] = '{2, 3, 0, 1, 4};
    if (uc <= 3'd4) return tbl[uc];
    if (uc == 3'd7 && rop.exists(fn)) return rop[fn];
    return 6;
  endfunction

  // m_cnt counts cycles since launch (0 = no operation in flight)
  int           m_cnt = 0;
  bit           ready = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit           p_dbz = 1'b0;

  always @(posedge clk) begin : model
    int           eo;
    bit           sgn;
    longint       sa, sb, q, r;
    logic [63:0]  p;
    if (rst) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; p_dbz = 1'b0; ready = 1'b1;
    end else if (ready) begin
      if (m_cnt == 0) begin
        eo = exp_op(UC_aluOp, func);
        if (valid_in && (eo == 7 || eo == 5)) begin
          sgn = (func == 6'b011000) || (func == 6'b011010);
          sa  = sgn ? longint'($signed(op_a)) : longint'({32'b0, op_a});
          sb  = sgn ? longint'($signed(op_b)) : longint'({32'b0, op_b});
          p_dbz = 1'b0;
          if (eo == 7) begin
            p = sa * sb;
            p_hi = p[63:32]; p_lo = p[31:0];
          end else if (op_b == 0) begin
            p_dbz = 1'b1; p_hi = op_a; p_lo = '1;
          end else begin
            q = sa / sb; r = sa % sb;
            p = q; p_lo = p[31:0];
            p = r; p_hi = p[31:0];
          end
          m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == W + 2) begin
          m_hi = p_hi; m_lo = p_lo; m_cnt = 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin : cmp
    int eo;
    bit e_launch, e_stall;
    if (ready) begin
      eo       = exp_op(UC_aluOp, func);
      e_launch = !rst && m_cnt == 0 && valid_in && (eo == 7 || eo == 5);
      e_stall  = !rst && (e_launch || (m_cnt >= 1 && m_cnt <= W));
      chk("m_op", ALU_aluOp, 64'(eo));
      chk("m_stall", stall, e_stall);
      chk("m_busy", md_busy, m_cnt != 0);
      chk("m_dbz", div_by_zero, (m_cnt == W + 1) && p_dbz);
      chk("m_hi", hi, m_hi);
      chk("m_lo", lo, m_lo);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input bit lit, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit edbz);
    int n = 0;
    bit ended = 1'b0;
    @(posedge clk); #2;
    valid_in = 1'b1; UC_aluOp = 3'b111; func = fn; op_a = a; op_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin ended = 1'b1; break; end
      n++;
    end
    chk("stall_end", ended, 1'b1);
    chk("stall_len", 64'(n), 64'(W + 1));
    chk("dbz_done", div_by_zero, edbz);
    @(posedge clk); #2;
    func = 6'b010000;
    @(negedge clk);
    chk("mfhi_op", ALU_aluOp, 4'h8);
    chk("mfhi_stall", stall, 1'b0);
    if (lit) begin
      chk("lit_hi", hi, ehi);
      chk("lit_lo", lo, elo);
    end
    chk("dbz_after", div_by_zero, 1'b0);
    @(posedge clk); #2;
    valid_in = 1'b0;
  endtask

  initial begin
    logic [5:0] fl [12] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b000000,
                            6'b010000, 6'b010010, 6'b011000, 6'b011010, 6'b111111, 6'b000001};
    int         fe [12] = '{0, 1, 2, 3, 4, 6, 8, 9, 7, 5, 6, 6};
    int         ue [7]  = '{2, 3, 0, 1, 4, 6, 6};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Decode table, valid_in low so nothing launches
    for (int u = 0; u < 7; u++) begin
      @(posedge clk); #2;
      UC_aluOp = 3'(u); func = 6'b011000;
      @(negedge clk);
      chk("dec_uc", ALU_aluOp, 64'(ue[u]));
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      UC_aluOp = 3'b111; func = fl[i];
      @(negedge clk);
      chk("dec_fn", ALU_aluOp, 64'(fe[i]));
      chk("dec_stall", stall, 1'b0);
    end
    // MULT decoded with valid_in low must not launch
    @(posedge clk); #2;
    func = 6'b011000;
    repeat (2) @(negedge clk);
    chk("novalid_busy", md_busy, 1'b0);

    run_md(6'b011000, 32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_md(6'b011010, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_md(6'b011010, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0);
    run_md(6'b011010, 32'h00001234, 32'h0, 1'b1, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    run_md(6'b011010, 32'd100, 32'hFFFFFFF9, 1'b1, 32'h2, 32'hFFFFFFF2, 1'b0);
    run_md(6'b011000, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 1'b0);
    run_md(6'b011000, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h0, 1'b0);

`ifdef ALUC_UNSIGNED_EN
    run_md(6'b011001, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h1, 32'hFFFFFFFE, 1'b0);
    run_md(6'b011011, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h1, 32'h7FFFFFFF, 1'b0);
    run_md(6'b011011, 32'h00000055, 32'h0, 1'b1, 32'h55, 32'hFFFFFFFF, 1'b1);
`else
    @(posedge clk); #2;
    valid_in = 1'b1; UC_aluOp = 3'b111; func = 6'b011001;
    @(negedge clk);
    chk("multu_off_op", ALU_aluOp, 4'h6);
    chk("multu_off_stall", stall, 1'b0);
    @(negedge clk);
    chk("multu_off_busy", md_busy, 1'b0);
    @(posedge clk); #2;
    valid_in = 1'b0;
`endif

    // Reset in the middle of a MULT
    @(posedge clk); #2;
    valid_in = 1'b1; UC_aluOp = 3'b111; func = 6'b011000; op_a = 32'd5; op_b = 32'd9;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    chk("rstmid_stall_c", stall, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", md_busy, 1'b0);
    chk("rstmid_stall", stall, 1'b0);
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    repeat (W + 6) @(negedge clk);
    chk("rstmid_late_hi", hi, 32'h0);
    chk("rstmid_late_lo", lo, 32'h0);
    chk("rstmid_late_busy", md_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
